// File: rtl/dac_spi_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_tx_pkg
// Brief    : Shared audio-path constants, DAC command framing and FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package dac_spi_tx_pkg;

    localparam int unsigned DAC_CMD_BITS  = 16;
    localparam int unsigned DAC_DATA_BITS = 10;

    localparam int unsigned CMD_BUF_POS   = 14;
    localparam int unsigned CMD_GA_POS    = 13;
    localparam int unsigned CMD_SHDN_POS  = 12;
    localparam int unsigned CMD_DATA_LSB  = 2;

    localparam logic [DAC_DATA_BITS-1:0] DAC_OFFSET = 10'h200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CS_HI = 2'd2,
        LDAC  = 2'd3
    } dac_state_e;

    // Bit 15 (write-to-DAC-A select) is always 0; the two LSBs are don't-care.
    function automatic logic [DAC_CMD_BITS-1:0] dac_cmd(
        input logic                     buf_en,
        input logic                     gain_n,
        input logic                     active_n,
        input logic [DAC_DATA_BITS-1:0] sample
    );
        logic [DAC_CMD_BITS-1:0] w_cmd;
        w_cmd                                   = '0;
        w_cmd[CMD_BUF_POS]                      = buf_en;
        w_cmd[CMD_GA_POS]                       = gain_n;
        w_cmd[CMD_SHDN_POS]                     = active_n;
        w_cmd[CMD_DATA_LSB +: DAC_DATA_BITS]    = sample;
        return w_cmd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_spi_tx_sck_divider.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_tx_sck_divider
// Brief    : Emits a one-cycle phase tick every CLK_DIV cycles; sync clear.
// Revision : 1.0 - initial release
// ============================================================================
module dac_spi_tx_sck_divider #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    output logic o_tick
);

    localparam int unsigned           c_DIV_W = $clog2(CLK_DIV);
    localparam logic [c_DIV_W-1:0]    c_TERM  = c_DIV_W'(CLK_DIV - 1);

    logic [c_DIV_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (r_cnt == c_TERM) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_DIV_W'(1);
        end
    end

    assign o_tick = (r_cnt == c_TERM) && !i_clr;

endmodule
`default_nettype wire

// File: rtl/dac_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : dac_spi_tx
// Brief    : Frames a 10-bit sample into a DAC command and shifts it out on
//            CS/SCK/SDI, then pulses LDAC. One-deep pending sample buffer.
// Revision : 1.0 - initial release
// ============================================================================
module dac_spi_tx
    import dac_spi_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = 25,
    parameter logic        BUF     = 1'b1,
    parameter logic        GA_N    = 1'b1,
    parameter logic        SHDN_N  = 1'b1
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic [DAC_DATA_BITS-1:0] data_in,
    input  logic                     load,
    output logic                     dac_cs_n,
    output logic                     dac_sck,
    output logic                     dac_sdi,
    output logic                     dac_ld_n,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    dac_state_e                r_state, w_state_nxt;
    logic [4:0]                r_half, w_half_nxt;
    logic [DAC_CMD_BITS-1:0]   r_word, w_word_nxt;
    logic [DAC_DATA_BITS-1:0]  r_pend;
    logic                      r_pend_vld;
    logic                      r_overrun;
    logic                      w_start;
    logic                      w_tick;
    logic                      w_div_clr;
    logic [3:0]                w_bit_idx;
    logic                      r_cs_n, r_sck, r_sdi, r_ld_n, r_busy, r_done;

    dac_spi_tx_sck_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_divider (
        .clk    (sysclk),
        .rst    (reset),
        .i_clr  (w_div_clr),
        .o_tick (w_tick)
    );

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state <= IDLE;
            r_half  <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_half  <= w_half_nxt;
            r_word  <= w_word_nxt;
        end
    end

    // r_half counts SCK half-periods: bit 0 is the SCK level, [4:1] the bit slot.
    always_comb begin
        w_state_nxt = r_state;
        w_half_nxt  = r_half;
        w_start     = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_pend_vld || load) begin
                    w_state_nxt = SHIFT;
                    w_half_nxt  = '0;
                    w_start     = 1'b1;
                end
            end
            SHIFT: begin
                if (w_tick) begin
                    if (r_half == 5'd31) begin
                        w_state_nxt = CS_HI;
                        w_half_nxt  = '0;
                    end else begin
                        w_half_nxt  = r_half + 5'd1;
                    end
                end
            end
            CS_HI:   if (w_tick) w_state_nxt = LDAC;
            LDAC:    if (w_tick) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        w_word_nxt = w_start ? dac_cmd(BUF, GA_N, SHDN_N, r_pend_vld ? r_pend : data_in)
                             : r_word;
        w_bit_idx  = 4'd15 - w_half_nxt[4:1];
        w_div_clr  = (r_state == IDLE);
    end

    // A queued sample takes priority when leaving IDLE; a coincident load refills the slot.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (r_state == IDLE) begin
            if (r_pend_vld) begin
                r_pend_vld <= load;
                if (load) r_pend <= data_in;
            end
        end else if (load) begin
            r_pend     <= data_in;
            r_pend_vld <= 1'b1;
            if (r_pend_vld) r_overrun <= 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_cs_n <= 1'b1;
            r_sck  <= 1'b0;
            r_sdi  <= 1'b0;
            r_ld_n <= 1'b1;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_cs_n <= (w_state_nxt != SHIFT);
            r_sck  <= (w_state_nxt == SHIFT) && w_half_nxt[0];
            r_sdi  <= (w_state_nxt == SHIFT) && w_word_nxt[w_bit_idx];
            r_ld_n <= (w_state_nxt != LDAC);
            r_busy <= (w_state_nxt != IDLE);
            r_done <= (r_state == LDAC) && (w_state_nxt == IDLE);
        end
    end

    assign dac_cs_n = r_cs_n;
    assign dac_sck  = r_sck;
    assign dac_sdi  = r_sdi;
    assign dac_ld_n = r_ld_n;
    assign busy     = r_busy;
    assign done     = r_done;
    assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
Serial transmitter that drives the board's 10-bit SPI DAC (MCP4911-class) from the processor's sample output.
- Captures a 10-bit offset-binary sample (DAC_OFFSET already added upstream) on a load strobe.
- Frames it into a 16-bit DAC command word and shifts it out MSB-first on CS/SCK/SDI.
- Pulses LDAC to update the analogue output.
- Sits between the audio processor's data_out register and the DAC pins; it is the output end of the ADC → processor → DAC sample path.

Parameters:
- CLK_DIV, 25: sysclk cycles per SCK half-period (50 MHz sysclk → 1 MHz SCK); legal range 2..255.
- BUF, 1: Vref buffer bit (command bit 14).
- GA_N, 1: gain bit, 1 = 1x (command bit 13).
- SHDN_N, 1: output-active bit (command bit 12).

Ports:
- sysclk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- data_in  in  10  offset-binary sample to convert.
- load  in  1  single-cycle strobe: capture data_in and transmit.
- dac_cs_n  out  1  DAC chip select, active low.
- dac_sck  out  1  serial clock; DAC samples SDI on the rising edge.
- dac_sdi  out  1  serial data, MSB first.
- dac_ld_n  out  1  LDAC, active-low latch pulse.
- busy  out  1  high from the cycle after an accepted load until return to IDLE.
- done  out  1  one-cycle pulse on the first IDLE cycle after a frame.
- overrun  out  1  sticky; set when a pending sample is overwritten; cleared only by reset.

Behaviour:
- Reset values: dac_cs_n=1, dac_sck=0, dac_sdi=0, dac_ld_n=1, busy=0, done=0, overrun=0. State=IDLE, pending register empty, divider and bit counter cleared.
- Reset asserted mid-frame aborts immediately with the above values on the next edge. No partial LDAC pulse may be issued.
- Command word: {1'b0, BUF, GA_N, SHDN_N, data_in[9:0], 2'b00}, built from the value captured at load.
- States:
  - IDLE → SHIFT: on load, or on a pending sample.
  - SHIFT → CS_HI: after 32*CLK_DIV cycles.
  - CS_HI → LDAC: after CLK_DIV cycles.
  - LDAC → IDLE: after CLK_DIV cycles.
- SHIFT timing:
  - The cycle after acceptance, dac_cs_n=0 and dac_sdi=bit15.
  - Each bit is CLK_DIV cycles with SCK low, then CLK_DIV cycles with SCK high.
  - SDI changes only on the SCK falling transition, and is stable during the whole SCK-high phase.
  - After the 16th high phase: SCK=0, SDI=0, CS=1.
- CS_HI: dac_cs_n=1 and dac_ld_n=1 for CLK_DIV cycles.
- LDAC: dac_ld_n=0 for exactly CLK_DIV cycles. CS stays high.
- Latency: load at cycle 0 → CS low at cycle 1 → CS high at cycle 1+32*CLK_DIV → ld_n low at 1+33*CLK_DIV → done at 1+34*CLK_DIV. With the default this is done at cycle 851.
- Busy handling:
  - load while busy stores data_in into a one-deep pending register.
  - A second load while pending is already full overwrites it and sets overrun.
  - On reaching IDLE with a pending sample, done pulses and the next frame starts the same cycle. CS goes low on the following cycle and pending clears.
- load asserted on the same cycle as the done/IDLE transition: treated as an IDLE load (accepted directly). No overrun.
- load held high for multiple cycles counts as one load per cycle. Upstream must strobe (pulse_gen output).
- Divider and bit counter widths: ceil(log2(CLK_DIV)) and 5 bits. No wrap except the defined terminal counts.

Decomposition:
- Shared audio package holds:
  - DAC_CMD_BITS=16.
  - Command-bit position constants.
  - DAC_OFFSET=10'h200.
  - State enum {IDLE, SHIFT, CS_HI, LDAC}.
- One natural sub-module: sck_divider. It generates a phase-tick every CLK_DIV cycles, with a synchronous clear, for use by the FSM.

Test Plan:
- Reset, then idle 100 cycles → cs_n=1, sck=0, ld_n=1, busy=0, done=0 throughout.
- load with data_in=10'h2A5, defaults → bits captured on 16 SCK rises = 16'h7A94, CS low cycles 1..800, ld_n low cycles 826..850, done at cycle 851.
- Sweep data_in 10'h000 and 10'h3FF → words 16'h7000 and 16'h7FFC; exactly 16 SCK rising edges per frame.
- load 10'h100 then load 10'h155 at cycle 200 → second frame's CS falls at cycle 852, word 16'h7554, overrun=0.
- Three loads within one frame (10'h001, 10'h002, 10'h003) → frames carry 10'h001 then 10'h003, overrun=1 and stays 1 until reset.
- reset asserted at cycle 400 mid-SHIFT → next edge cs_n=1, sck=0, busy=0, ld_n never low. A new load at cycle 410 produces a clean full frame.
